// File: rtl/delay_sum_beamformer.sv
// -----------------------------------------------------------------------------
// delay_sum_beamformer
//
// Purpose:
//   Consumer end of the delay module. On a sample strobe it snapshots all
//   NUM_CH delayed PCM channels. It then sums them serially with one adder,
//   one channel per clock. The sum is rounded (half up), arithmetically shifted
//   and saturated. The resulting beamformed sample is presented on a
//   valid/ready output port.
//
// Ports:
//   clk            in   1              system clock
//   rst            in   1              synchronous reset, active-high
//   sample_valid   in   1              one-cycle strobe: pcm_data holds a new set
//   pcm_data       in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//   ch_mask        in   NUM_CH         (CHANNEL_MASK_EN only) 0 bit mutes channel
//   out_data       out  OUT_W          signed beamformed sample
//   out_valid      out  1              out_data valid, held until out_ready
//   out_ready      in   1              downstream accepts out_data
//   busy           out  1              high while accumulating or presenting
//   overrun        out  1              one-cycle pulse: a strobe was dropped
//   overrun_count  out  8              saturating count of dropped strobes
//
// Configuration macro:
//   CHANNEL_MASK_EN - adds the ch_mask port. The mask is captured together with
//                     the snapshot. Masked channels contribute zero, and timing
//                     is unchanged.
// -----------------------------------------------------------------------------
module delay_sum_beamformer #(
  parameter int NUM_CH    = 16,
  parameter int DATA_W    = 19,
  parameter int OUT_SHIFT = 4,
  parameter int OUT_W     = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [NUM_CH*DATA_W-1:0]   pcm_data,
`ifdef CHANNEL_MASK_EN
  input  logic [NUM_CH-1:0]          ch_mask,
`endif
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       overrun,
  output logic [7:0]                 overrun_count
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int ACC_W = DATA_W + CH_W;
  // One extra index value marks the "all channels added, now scale" cycle.
  localparam int IDX_W = CH_W + 1;

  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) <<< RND_SH) : '0;
  localparam logic signed [ACC_W:0] OUT_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [DATA_W-1:0]    snap_q [NUM_CH];
  logic signed [DATA_W-1:0]    snap_d [NUM_CH];
  logic signed [OUT_W-1:0]     out_data_q, out_data_d;
  logic                        overrun_q, overrun_d;
  logic [7:0]                  ovr_cnt_q, ovr_cnt_d;
`ifdef CHANNEL_MASK_EN
  logic [NUM_CH-1:0]           mask_q, mask_d;
`endif

  logic                        accept;
  logic                        drop;
  logic [CH_W-1:0]             idx_lo;
  logic signed [ACC_W-1:0]     term;
  logic signed [ACC_W:0]       acc_rnd;
  logic signed [ACC_W:0]       scaled;
  logic signed [OUT_W-1:0]     sat_val;

  // Round, shift and saturate the finished accumulator. The sum carries one
  // guard bit so that adding the rounding term can never wrap.
  always_comb begin
    acc_rnd = {acc_q[ACC_W-1], acc_q} + RND;
    scaled  = acc_rnd >>> OUT_SHIFT;
    sat_val = scaled[OUT_W-1:0];
    if (scaled > OUT_MAX) begin
      sat_val = OUT_MAX[OUT_W-1:0];
    end else if (scaled < OUT_MIN) begin
      sat_val = OUT_MIN[OUT_W-1:0];
    end
  end

  // Next-state logic.
  // A new sample can only enter when the datapath is idle, or when the held
  // result is leaving in this very cycle. Any other strobe is counted as dropped.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    snap_d     = snap_q;
    out_data_d = out_data_q;
    ovr_cnt_d  = ovr_cnt_q;
`ifdef CHANNEL_MASK_EN
    mask_d     = mask_q;
`endif

    accept    = sample_valid &&
                ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
    drop      = sample_valid && !accept;
    overrun_d = drop;
    if (drop && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    idx_lo = idx_q[CH_W-1:0];
`ifdef CHANNEL_MASK_EN
    term = mask_q[idx_lo] ? ACC_W'(snap_q[idx_lo]) : '0;
`else
    term = ACC_W'(snap_q[idx_lo]);
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (idx_q == IDX_W'(NUM_CH)) begin
          out_data_d = sat_val;
          state_d    = S_OUT;
        end else begin
          acc_d = acc_q + term;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An accept always restarts the accumulation from a fresh snapshot.
    // This overrides the handshake transition back to idle.
    if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap_d[i] = pcm_data[i*DATA_W +: DATA_W];
      end
`ifdef CHANNEL_MASK_EN
      mask_d  = ch_mask;
`endif
      acc_d   = '0;
      idx_d   = '0;
      state_d = S_ACC;
    end
  end

  // State registers. Reset discards any sample that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      overrun_q  <= 1'b0;
      ovr_cnt_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= '0;
      end
`ifdef CHANNEL_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      overrun_q  <= overrun_d;
      ovr_cnt_q  <= ovr_cnt_d;
      snap_q     <= snap_d;
`ifdef CHANNEL_MASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = (state_q == S_OUT);
  assign busy          = (state_q != S_IDLE);
  assign overrun       = overrun_q;
  assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// -----------------------------------------------------------------------------
// tb_delay_sum_beamformer
//
// Self-checking bench for delay_sum_beamformer.
// A table of directed vectors is applied first, followed by randomized sample
// sets. Each randomized set is checked against an arithmetic reference model.
// Hand-written sequences cover backpressure/overrun, mid-sum reset and counter
// saturation. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_delay_sum_beamformer;

  localparam int NUM_CH    = 16;
  localparam int DATA_W    = 19;
  localparam int OUT_SHIFT = 4;
  localparam int OUT_W     = 19;
  localparam int LATENCY   = NUM_CH + 1;

  logic                      clk;
  logic                      rst;
  logic                      sample_valid;
  logic [NUM_CH*DATA_W-1:0]  pcm_data;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic                      overrun;
  logic [7:0]                overrun_count;
`ifdef CHANNEL_MASK_EN
  logic [NUM_CH-1:0]         ch_mask;
`endif

  int checks   = 0;
  int failures = 0;

  delay_sum_beamformer #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .OUT_SHIFT (OUT_SHIFT),
    .OUT_W     (OUT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .pcm_data      (pcm_data),
`ifdef CHANNEL_MASK_EN
    .ch_mask       (ch_mask),
`endif
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                     name;
    logic [NUM_CH*DATA_W-1:0]  data;
    longint                    expected;
  } vec_t;

  vec_t vecs [7];

  // Replicates one value into every channel slot.
  function automatic logic [NUM_CH*DATA_W-1:0] fill_all(input logic [DATA_W-1:0] v);
    logic [NUM_CH*DATA_W-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = v;
    return d;
  endfunction

  // Reference: mean-style scaling of the plain integer sum, computed as
  // floor((sum + half) / 2^shift) and clamped to the signed output range.
  function automatic longint model_beam(input logic [NUM_CH*DATA_W-1:0] d,
                                        input logic [NUM_CH-1:0] mask);
    longint sum = 0;
    longint r;
    longint lo = -(longint'(1) << (OUT_W - 1));
    longint hi = (longint'(1) << (OUT_W - 1)) - 1;
    logic signed [DATA_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) begin
      v = d[i*DATA_W +: DATA_W];
      if (mask[i]) sum += longint'(v);
    end
    if (OUT_SHIFT > 0) sum += longint'(1) << (OUT_SHIFT - 1);
    r = sum >>> OUT_SHIFT;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Waits at falling edges for out_valid, returning the number of cycles waited.
  task automatic wait_result(output int lat);
    int cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) check_output("out_valid_timeout", 0, 1);
    lat = cyc;
  endtask

  // Strobes one sample set with out_ready high, then checks the latency and the
  // result. Finally checks that out_valid drops after the handshake.
  task automatic apply_stimulus(input string name, input logic [NUM_CH*DATA_W-1:0] d,
                                input longint expected);
    int lat;
    out_ready    = 1'b1;
    pcm_data     = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_result(lat);
    check_output({name, "_latency"}, lat, LATENCY);
    check_output(name, longint'(out_data), expected);
    @(negedge clk);
    check_output({name, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [NUM_CH*DATA_W-1:0] d;
    logic [NUM_CH-1:0]        all_on;
    int                       lat;
    bit                       stable;
    bit                       seen_valid;

    all_on       = '1;
    rst          = 1'b1;
    sample_valid = 1'b0;
    pcm_data     = '0;
    out_ready    = 1'b1;
`ifdef CHANNEL_MASK_EN
    ch_mask      = '1;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_count", overrun_count, 0);
    check_output("rst_out_data", longint'(out_data), 0);

    // Directed table
    for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = DATA_W'(i);
    vecs[0] = '{"all_one",  fill_all(19'd1),       1};
    vecs[1] = '{"all_five", fill_all(19'd5),       5};
    vecs[2] = '{"all_neg1", fill_all(19'h7FFFF),  -1};
    vecs[3] = '{"ramp",     d,                     8};
    vecs[4] = '{"max_pos",  fill_all(19'h3FFFF),   262143};
    vecs[5] = '{"max_neg",  fill_all(19'h40000),  -262144};
    vecs[6] = '{"all_16",   fill_all(19'd16),      16};

    for (int t = 0; t < 7; t++) begin
      apply_stimulus(vecs[t].name, vecs[t].data, vecs[t].expected);
    end

`ifdef CHANNEL_MASK_EN
    ch_mask = 16'h00FF;
    apply_stimulus("mask_low8", fill_all(19'd16), 8);
    ch_mask = '1;
`endif

    // Randomized sets: alternate full-range and small-range channel values
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (t[0]) d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        else      d[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 40) - 20);
      end
      apply_stimulus("random", d, model_beam(d, all_on));
    end

    // Backpressure: drops during accumulation and while holding a result
    out_ready    = 1'b0;
    pcm_data     = fill_all(19'd3);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check_output("ovr_acc_pulse", overrun, 1);
    check_output("ovr_acc_count", overrun_count, 1);
    @(negedge clk);
    check_output("ovr_pulse_end", overrun, 0);
    wait_result(lat);
    check_output("bp_data", longint'(out_data), 3);
    stable = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (!out_valid || out_data !== 19'sd3) stable = 1'b0;
    end
    check_output("bp_hold_stable", stable, 1);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check_output("ovr_out_pulse", overrun, 1);
    check_output("ovr_out_count", overrun_count, 2);
    check_output("ovr_out_data", longint'(out_data), 3);
    check_output("ovr_out_valid", out_valid, 1);
    repeat (4) @(negedge clk);
    // Strobe in the handshake cycle is accepted back to back
    out_ready    = 1'b1;
    pcm_data     = fill_all(19'd7);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check_output("b2b_valid_low", out_valid, 0);
    check_output("b2b_busy", busy, 1);
    check_output("b2b_no_overrun", overrun, 0);
    check_output("b2b_count", overrun_count, 2);
    wait_result(lat);
    check_output("b2b_latency", lat, LATENCY);
    check_output("b2b_data", longint'(out_data), 7);
    @(negedge clk);
    check_output("b2b_valid_drop", out_valid, 0);

    // Reset in the middle of accumulation
    pcm_data     = fill_all(19'd9);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_count", overrun_count, 0);
    check_output("mid_rst_data", longint'(out_data), 0);
    seen_valid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check_output("mid_rst_no_valid", seen_valid, 0);
    apply_stimulus("post_rst", fill_all(19'd2), 2);

    // Overrun counter saturation
    out_ready    = 1'b0;
    pcm_data     = fill_all(19'd1);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_result(lat);
    sample_valid = 1'b1;
    repeat (300) @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    check_output("count_saturate", overrun_count, 255);
    check_output("sat_data_held", longint'(out_data), 1);
    out_ready = 1'b1;
    do_reset();
    check_output("final_rst_count", overrun_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
